// File: rtl/score_display.sv
// Four-digit seven-segment driver: high score on digits 3..2, current score on 1..0.
// Binary to BCD goes through a shared sequential double-dabble engine.
module score_display #(
  parameter int REFRESH_BITS = 18,
  parameter int BLINK_BITS   = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] score,
  input  logic       colision,
  input  logic       start,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic [5:0] hi_score
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  state_t                  state_q;
  logic                    src_hi_q;
  logic [5:0]              cap_q, bin_q, cur_last_q, hi_last_q, hi_q;
  logic [7:0]              bcd_q, bcd_d;
  logic [2:0]              cnt_q;
  logic [3:0]              cur_t_q, cur_u_q, hi_t_q, hi_u_q;
  logic                    start_q;
  logic [REFRESH_BITS-1:0] ref_q;
  logic [BLINK_BITS-1:0]   blink_q;
  logic [3:0]              an_q, an_d;
  logic [7:0]              seg_q, seg_d;
  logic [1:0]              sel;
  logic [6:0]              glyph_d;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // Double-dabble correction applied before each shift
  always_comb begin
    bcd_d = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_d[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_d[7:4] = bcd_q[7:4] + 4'd3;
  end

  assign sel = ref_q[REFRESH_BITS-1 -: 2];

  always_comb begin
    case (sel)
      2'd0:    glyph_d = glyph(cur_u_q);
      2'd1:    glyph_d = (cur_t_q == 4'd0) ? 7'h7F : glyph(cur_t_q);
      2'd2:    glyph_d = glyph(hi_u_q);
      default: glyph_d = (hi_t_q == 4'd0) ? 7'h7F : glyph(hi_t_q);
    endcase
    // Dash until the game has started; blink only applies once running
    if (!sel[1]) begin
      if (!start_q)                              glyph_d = 7'b0111111;
      else if (colision && blink_q[BLINK_BITS-1]) glyph_d = 7'h7F;
    end
    seg_d = {(sel != 2'd2), glyph_d};
    an_d  = ~(4'b0001 << sel);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      src_hi_q   <= 1'b0;
      cap_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      cur_last_q <= '0;
      hi_last_q  <= '0;
      hi_q       <= '0;
      cur_t_q    <= '0;
      cur_u_q    <= '0;
      hi_t_q     <= '0;
      hi_u_q     <= '0;
      start_q    <= 1'b0;
      ref_q      <= '0;
      blink_q    <= '0;
      an_q       <= 4'hF;
      seg_q      <= 8'hFF;
    end else begin
      ref_q   <= ref_q + 1'b1;
      blink_q <= blink_q + 1'b1;
      an_q    <= an_d;
      seg_q   <= seg_d;
      if (start) start_q <= 1'b1;
      if (score > hi_q) hi_q <= score;
      case (state_q)
        IDLE: begin
          if (score != cur_last_q) begin
            src_hi_q <= 1'b0;
            state_q  <= LOAD;
          end else if (hi_q != hi_last_q) begin
            src_hi_q <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          cap_q   <= src_hi_q ? hi_q : score;
          bin_q   <= src_hi_q ? hi_q : score;
          bcd_q   <= '0;
          cnt_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_d, bin_q} << 1;
          cnt_q          <= cnt_q + 3'd1;
          if (cnt_q == 3'd5) state_q <= COMMIT;
        end
        default: begin
          if (src_hi_q) begin
            hi_t_q    <= bcd_q[7:4];
            hi_u_q    <= bcd_q[3:0];
            hi_last_q <= cap_q;
          end else begin
            cur_t_q    <= bcd_q[7:4];
            cur_u_q    <= bcd_q[3:0];
            cur_last_q <= cap_q;
          end
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign hi_score = hi_q;

endmodule

// File: tb/tb_score_display.sv
// Randomized bench for score_display against a decimal-arithmetic reference model.
module tb_score_display;
  localparam int RB = 4;
  localparam int BB = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] score = '0;
  logic       colision = 1'b0;
  logic       start = 1'b0;
  logic [3:0] an;
  logic [7:0] seg;
  logic [5:0] hi_score;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int   m_hi, m_cur, m_hiv, m_busy, m_src, m_cap, m_ref, m_blk;
  bit   m_start;
  int   m_an, m_seg;

  score_display #(.REFRESH_BITS(RB), .BLINK_BITS(BB)) dut (
    .clk(clk), .reset(reset), .score(score), .colision(colision), .start(start),
    .an(an), .seg(seg), .hi_score(hi_score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int digit_glyph(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  default: return 7'b0010000;
    endcase
  endfunction

  function automatic int exp_seg(input int sel, input bit col);
    int v, g;
    v = (sel < 2) ? m_cur : m_hiv;
    if (sel % 2 == 1) g = (v / 10 == 0) ? 7'h7F : digit_glyph(v / 10);
    else              g = digit_glyph(v % 10);
    if (sel < 2 && !m_start)                        g = 7'h3F;
    else if (sel < 2 && col && ((m_blk >> (BB-1)) & 1)) g = 7'h7F;
    return ((sel == 2) ? 0 : 128) + g;
  endfunction

  task automatic model_reset();
    m_hi = 0; m_cur = 0; m_hiv = 0; m_busy = 0; m_src = 0; m_cap = 0;
    m_ref = 0; m_blk = 0; m_start = 0; m_an = 4'hF; m_seg = 8'hFF;
  endtask

  // Advance the model across one rising edge with the given inputs
  task automatic model_step(input int sc, input bit col, input bit st);
    int sel;
    sel   = (m_ref >> (RB-2)) & 3;
    m_an  = 15 - (1 << sel);
    m_seg = exp_seg(sel, col);
    if (m_busy == 0) begin
      if (sc != m_cur)       begin m_busy = 1; m_src = 0; end
      else if (m_hi != m_hiv) begin m_busy = 1; m_src = 1; end
    end else if (m_busy == 1) begin
      m_cap = m_src ? m_hi : sc;
      m_busy = 2;
    end else if (m_busy < 8) begin
      m_busy++;
    end else begin
      if (m_src) m_hiv = m_cap; else m_cur = m_cap;
      m_busy = 0;
    end
    m_ref = (m_ref + 1) % (1 << RB);
    m_blk = (m_blk + 1) % (1 << BB);
    if (st) m_start = 1;
    if (sc > m_hi) m_hi = sc;
  endtask

  // Called at a falling edge: check outputs, drive next inputs, advance model
  task automatic tick(input int sc, input bit col, input bit st, input bit rs);
    bit rise;
    chk("an", an, m_an);
    chk("seg", seg, m_seg);
    chk("hi_score", hi_score, m_hi);
    rise     = rs && !reset;
    score    = sc[5:0];
    colision = col;
    start    = st;
    reset    = rs;
    if (rs) model_reset();
    else    model_step(sc, col, st);
    if (rise) begin
      #1;
      chk("async_an", an, 4'hF);
      chk("async_seg", seg, 8'hFF);
      chk("async_hi", hi_score, 0);
    end
    @(negedge clk);
  endtask

  initial begin
    int sc;
    bit col, st, rs;
    model_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    repeat (3) tick(0, 0, 0, 1);
    repeat (70) tick(0, 1, 0, 0);        // dashes must win over blink
    tick(0, 0, 1, 0);
    repeat (30) tick(42, 0, 0, 0);
    repeat (25) tick(63, 0, 0, 0);
    repeat (25) tick(17, 0, 0, 0);
    repeat (25) tick(9, 0, 0, 0);
    repeat (150) tick(25, 1, 0, 0);
    repeat (20) tick(25, 0, 0, 0);
    repeat (4) tick(10, 0, 0, 0);        // change lands on the third shift
    repeat (30) tick(11, 0, 0, 0);
    repeat (30) tick(50, 0, 0, 0);
    repeat (4) tick(30, 0, 0, 0);
    repeat (3) tick(30, 0, 0, 1);
    tick(50, 0, 1, 0);
    repeat (40) tick(50, 0, 0, 0);
    sc = 50; col = 0;
    repeat (600) begin
      if ($urandom_range(0, 11) == 0) sc = $urandom_range(0, 63);
      if ($urandom_range(0, 39) == 0) col = !col;
      st = ($urandom_range(0, 29) == 0);
      rs = ($urandom_range(0, 249) == 0);
      tick(sc, col, st, rs);
    end
    tick(sc, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
